// File: rtl/instr_fetch_unit.sv
// Program-counter owner and instruction fetcher for KGPminiRISC. Fetches one
// instruction at a time over a req/ack handshake and hands it to decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd1,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    output logic [31:0] PC,
    output logic [31:0] PC_incremented,
    input  logic [31:0] PC_new,
    input  logic        pc_update,
    input  logic        halt,
    output logic        halted,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        S_ISSUE,
        S_WAIT,
        S_EXEC,
        S_HALT,
        S_ERROR
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] instr_q, instr_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;
    logic        halted_q, halted_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        instr_d  = instr_q;
        req_d    = req_q;
        valid_d  = valid_q;
        halted_d = halted_q;
        err_d    = err_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_ISSUE: begin
                req_d   = 1'b1;
                addr_d  = pc_q;
                cnt_d   = 8'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // An ack on the last allowed cycle still wins over the timeout.
                if (imem_ack) begin
                    instr_d = imem_rdata;
                    valid_d = 1'b1;
                    req_d   = 1'b0;
                    state_d = S_EXEC;
                end else if (cnt_q == WAIT_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_EXEC: begin
                if (halt) begin
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                    state_d  = S_HALT;
                end else if (pc_update) begin
                    pc_d    = PC_new;
                    valid_d = 1'b0;
                    state_d = S_ISSUE;
                end
            end
            S_HALT, S_ERROR: begin
                req_d = 1'b0;
            end
            default: begin
                state_d = S_ISSUE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_ISSUE;
            pc_q     <= RESET_PC;
            addr_q   <= 32'd0;
            instr_q  <= 32'd0;
            req_q    <= 1'b0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= 8'd0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            instr_q  <= instr_d;
            req_q    <= req_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            err_q    <= err_d;
            cnt_q    <= cnt_d;
        end
    end

    assign imem_req       = req_q;
    assign imem_addr      = addr_q;
    assign instr          = instr_q;
    assign instr_valid    = valid_q;
    assign PC             = pc_q;
    assign PC_incremented = pc_q + PC_STEP;
    assign halted         = halted_q;
    assign fetch_err      = err_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a randomized memory responder and
// program driver feed expected fetches into queues that a monitor retires.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_STEP  = 32'd1;
    localparam int          MAX_WAIT = 16;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] PC;
    logic [31:0] PC_incremented;
    logic [31:0] PC_new;
    logic        pc_update;
    logic        halt;
    logic        halted;
    logic        fetch_err;

    instr_fetch_unit #(
        .RESET_PC(RESET_PC),
        .PC_STEP (PC_STEP),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .PC            (PC),
        .PC_incremented(PC_incremented),
        .PC_new        (PC_new),
        .pc_update     (pc_update),
        .halt          (halt),
        .halted        (halted),
        .fetch_err     (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] model_pc;
    bit          exp_halted;
    bit          exp_err;
    int          ack_delay;
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];
    logic [31:0] held_addr;
    logic [31:0] held_instr;
    logic        prev_req;
    logic        prev_valid;
    logic [31:0] saved_pc;

    // Instruction memory contents: a fixed word at 0, a hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        h = a * 32'h9E37_79B1;
        if (a == 32'd0) return 32'h1234_5678;
        return h ^ 32'h5A5A_A5A5;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: actual %h, required %h", name, actual, expected);
        end
    endtask

    // Memory responder: acks after ack_delay idle WAIT cycles, and sprinkles
    // stray acks with junk data whenever no fetch is outstanding.
    initial begin : responder
        int wait_cnt;
        wait_cnt   = 0;
        imem_ack   = 1'b0;
        imem_rdata = 32'd0;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && imem_req) begin
                if (wait_cnt == ack_delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem_word(imem_addr);
                    wait_cnt   = 0;
                end else begin
                    imem_ack   = 1'b0;
                    imem_rdata = $urandom;
                    wait_cnt++;
                end
            end else begin
                wait_cnt   = 0;
                imem_ack   = ($urandom_range(0, 1) == 1);
                imem_rdata = $urandom;
            end
        end
    end

    // Monitor: retires scoreboard entries on each new request or capture.
    initial begin : monitor
        prev_req   = 1'b0;
        prev_valid = 1'b0;
        held_addr  = 32'd0;
        held_instr = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req   = 1'b0;
                prev_valid = 1'b0;
            end else begin
                checkOutput("pc", PC, model_pc);
                checkOutput("pc_incremented", PC_incremented, model_pc + PC_STEP);
                checkOutput("halted", 32'(halted), 32'(exp_halted));
                checkOutput("fetch_err", 32'(fetch_err), 32'(exp_err));
                if (exp_halted || exp_err) begin
                    checkOutput("absorb_req", 32'(imem_req), 32'd0);
                    checkOutput("absorb_valid", 32'(instr_valid), 32'd0);
                end
                if (imem_req && !prev_req) begin
                    if (exp_addr_q.size() == 0) begin
                        checkOutput("spurious_req", 32'(imem_req), 32'd0);
                    end else begin
                        held_addr = exp_addr_q.pop_front();
                        checkOutput("fetch_addr", imem_addr, held_addr);
                    end
                end else if (imem_req) begin
                    checkOutput("addr_stable", imem_addr, held_addr);
                end
                if (instr_valid && !prev_valid) begin
                    if (exp_instr_q.size() == 0) begin
                        checkOutput("spurious_capture", 32'(instr_valid), 32'd0);
                    end else begin
                        held_instr = exp_instr_q.pop_front();
                        checkOutput("instr", instr, held_instr);
                    end
                end else if (instr_valid) begin
                    checkOutput("instr_hold", instr, held_instr);
                end
                prev_req   = imem_req;
                prev_valid = instr_valid;
            end
        end
    end

    task automatic randomControls();
        pc_update = ($urandom_range(0, 1) == 1);
        halt      = ($urandom_range(0, 1) == 1);
        PC_new    = $urandom;
    endtask

    // Waits for decode to hold an instruction, poking pc_update/halt meanwhile.
    task automatic waitValid();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (instr_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            randomControls();
            @(posedge clk);
            #1;
        end
        pc_update = 1'b0;
        halt      = 1'b0;
        if (!ok) checkOutput("valid_timeout", 32'(instr_valid), 32'd1);
    endtask

    task automatic noiseCycles(input int n);
        repeat (n) begin
            randomControls();
            @(posedge clk);
            #1;
        end
        pc_update = 1'b0;
        halt      = 1'b0;
    endtask

    // Retires the current instruction after exec_cycles of EXEC; the next
    // fetch (if any) is answered after 'delay' idle WAIT cycles.
    task automatic applyStimulus(input logic [31:0] new_pc, input int exec_cycles,
                                 input bit do_halt, input bit do_upd, input int delay);
        waitValid();
        ack_delay = delay;
        repeat (exec_cycles) begin
            @(posedge clk);
            #1;
        end
        PC_new    = new_pc;
        pc_update = do_upd;
        halt      = do_halt;
        @(posedge clk);
        if (do_halt) begin
            exp_halted = 1'b1;
        end else if (do_upd) begin
            model_pc = new_pc;
            exp_addr_q.push_back(new_pc);
            if (delay < MAX_WAIT) exp_instr_q.push_back(mem_word(new_pc));
        end
        #1;
        pc_update = 1'b0;
        halt      = 1'b0;
    endtask

    task automatic assertReset();
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_req", 32'(imem_req), 32'd0);
        checkOutput("rst_valid", 32'(instr_valid), 32'd0);
        checkOutput("rst_fetch_err", 32'(fetch_err), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_pc", PC, RESET_PC);
        exp_addr_q.delete();
        exp_instr_q.delete();
        model_pc   = RESET_PC;
        exp_halted = 1'b0;
        exp_err    = 1'b0;
    endtask

    task automatic releaseReset(input int delay);
        ack_delay = delay;
        exp_addr_q.push_back(RESET_PC);
        if (delay < MAX_WAIT) exp_instr_q.push_back(mem_word(RESET_PC));
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #600000;
        $display("[TB] FAIL watchdog: actual still running, required finished");
        $fatal(1, "[TB] time limit exceeded");
    end

    initial begin : driver
        rst_n      = 1'b0;
        pc_update  = 1'b0;
        halt       = 1'b0;
        PC_new     = 32'd0;
        ack_delay  = 0;
        model_pc   = RESET_PC;
        exp_halted = 1'b0;
        exp_err    = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_req", 32'(imem_req), 32'd0);
        checkOutput("reset_addr", imem_addr, 32'd0);
        checkOutput("reset_instr", instr, 32'd0);
        checkOutput("reset_valid", 32'(instr_valid), 32'd0);
        checkOutput("reset_halted", 32'(halted), 32'd0);
        checkOutput("reset_fetch_err", 32'(fetch_err), 32'd0);
        checkOutput("reset_pc", PC, RESET_PC);
        checkOutput("reset_pc_inc", PC_incremented, 32'd1);

        // First fetch: request one cycle after release, capture the next.
        releaseReset(0);
        checkOutput("first_req", 32'(imem_req), 32'd1);
        checkOutput("first_addr", imem_addr, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("first_valid", 32'(instr_valid), 32'd1);
        checkOutput("first_instr", instr, 32'h1234_5678);
        checkOutput("first_pc_inc", PC_incremented, 32'd1);

        // Redirect to 0x40; that fetch is answered after 5 idle WAIT cycles.
        applyStimulus(32'h0000_0040, 1, 1'b0, 1'b1, 5);
        checkOutput("redirect_valid_falls", 32'(instr_valid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("redirect_req", 32'(imem_req), 32'd1);
        checkOutput("redirect_addr", imem_addr, 32'h0000_0040);
        checkOutput("redirect_pc_inc", PC_incremented, 32'h0000_0041);

        for (int n = 0; n < 16; n++) begin
            applyStimulus($urandom, int'($urandom_range(0, 3)), 1'b0, 1'b1,
                          (n == 0) ? MAX_WAIT - 1 : int'($urandom_range(0, 14)));
        end

        // PC wrap, then reset in the middle of a WAIT.
        applyStimulus(32'hFFFF_FFFF, 0, 1'b0, 1'b1, 12);
        checkOutput("wrap_pc", PC, 32'hFFFF_FFFF);
        checkOutput("wrap_pc_inc", PC_incremented, 32'd0);
        @(posedge clk);
        #1;
        checkOutput("wrap_req", 32'(imem_req), 32'd1);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        assertReset();
        releaseReset(3);

        // halt together with pc_update: halt wins, PC stays put.
        applyStimulus($urandom, 0, 1'b0, 1'b1, 2);
        waitValid();
        saved_pc = model_pc;
        applyStimulus(32'h0000_0080, 2, 1'b1, 1'b1, 0);
        noiseCycles(20);
        checkOutput("halt_pc", PC, saved_pc);
        checkOutput("halt_halted", 32'(halted), 32'd1);
        checkOutput("halt_req", 32'(imem_req), 32'd0);

        assertReset();
        releaseReset(1);
        for (int n = 0; n < 4; n++) begin
            applyStimulus($urandom, int'($urandom_range(0, 2)), 1'b0, 1'b1,
                          int'($urandom_range(0, 7)));
        end

        // Withheld ack: error exactly after MAX_WAIT WAIT cycles.
        applyStimulus($urandom, 1, 1'b0, 1'b1, 255);
        repeat (MAX_WAIT) @(posedge clk);
        #1;
        checkOutput("timeout_err_early", 32'(fetch_err), 32'd0);
        checkOutput("timeout_req_early", 32'(imem_req), 32'd1);
        @(posedge clk);
        exp_err = 1'b1;
        #1;
        checkOutput("timeout_err", 32'(fetch_err), 32'd1);
        checkOutput("timeout_req", 32'(imem_req), 32'd0);
        saved_pc = model_pc;
        noiseCycles(20);
        checkOutput("error_pc", PC, saved_pc);
        checkOutput("error_sticky", 32'(fetch_err), 32'd1);

        assertReset();
        releaseReset(2);
        waitValid();
        @(negedge clk);
        #1;
        checkOutput("pending_addr", 32'(exp_addr_q.size()), 32'd0);
        checkOutput("pending_instr", 32'(exp_instr_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream neighbour of branch_unit in the KGPminiRISC datapath.
- Owns the program counter and fetches instructions from a variable-latency instruction memory using a req/ack handshake.
- Presents the fetched instruction to decode, and supplies PC_incremented to the branch unit.
- Loads the branch unit's PC_new when the core retires the instruction. Supports halt, and reports an error when a fetch times out.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_STEP, 1, PC increment per instruction (instruction memory is word-addressed).
- MAX_WAIT, 16, number of WAIT cycles without imem_ack before a fetch error is flagged (range 1..255).

Ports:
- clk  in  1  single clock, all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  32  fetch address, held stable while imem_req=1.
- imem_ack  in  1  memory reports that imem_rdata is valid this cycle.
- imem_rdata  in  32  instruction word from memory.
- instr  out  32  latched instruction for decode.
- instr_valid  out  1  instr holds the current instruction.
- PC  out  32  address of the current instruction.
- PC_incremented  out  32  PC + PC_STEP, feeds branch_unit.
- PC_new  in  32  next PC from branch_unit.
- pc_update  in  1  core retires the instruction; load PC_new.
- halt  in  1  decoded halt instruction; stop fetching.
- halted  out  1  fetch permanently stopped.
- fetch_err  out  1  fetch timeout, sticky.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State=ISSUE, PC=RESET_PC, imem_req=0, imem_addr=0, instr=0.
  - instr_valid=0, halted=0, fetch_err=0, wait counter=0.
  - Assertion mid-fetch aborts the fetch immediately; imem_req drops without waiting for ack.
- PC_incremented: combinational, (PC + PC_STEP) mod 2^32. 32'hFFFF_FFFF + 1 wraps to 0.
- FSM states: ISSUE, WAIT, EXEC, HALT, ERROR.
- ISSUE (1 cycle): registers imem_req<=1, imem_addr<=PC, wait counter<=0; next state WAIT.
- WAIT:
  - imem_req stays 1 and imem_addr stays stable.
  - imem_ack=1: instr<=imem_rdata, instr_valid<=1, imem_req<=0; next state EXEC.
  - imem_ack=0: counter increments. When counter reaches MAX_WAIT-1 with no ack: imem_req<=0, fetch_err<=1; next state ERROR.
  - Minimum latency is 2 cycles from entering ISSUE to instr_valid=1 (ack in the first WAIT cycle).
- EXEC:
  - instr and instr_valid are held.
  - halt=1: instr_valid<=0, halted<=1, PC unchanged; next state HALT. halt has priority over a simultaneous pc_update.
  - pc_update=1 (halt=0): PC<=PC_new (any 32-bit value accepted), instr_valid<=0; next state ISSUE.
  - Neither asserted: remain in EXEC indefinitely.
- HALT and ERROR: absorbing until reset. imem_req=0; all inputs ignored.
- Inputs outside their valid state:
  - pc_update and halt outside EXEC are ignored.
  - imem_ack outside WAIT is ignored, and imem_rdata is not captured.
- Throughput: no overlap between fetches; each instruction costs at least 3 cycles (ISSUE, WAIT, EXEC).

Test Plan:
1. Reset release with RESET_PC=0 and ack on the first WAIT cycle, imem_rdata=32'h1234_5678:
   - imem_req=1 with imem_addr=0 one cycle after reset release.
   - instr_valid=1 and instr=32'h1234_5678 the next cycle.
   - PC_incremented=1.
2. In EXEC, pulse pc_update with PC_new=32'h0000_0040:
   - instr_valid falls the next cycle.
   - Following cycle: imem_addr=32'h40, PC_incremented=32'h41.
3. Delay ack by 5 cycles (MAX_WAIT=16):
   - imem_req held high with a stable address for all 5 cycles.
   - Single capture; fetch_err stays 0.
4. Withhold ack:
   - fetch_err=1 and imem_req=0 after exactly 16 WAIT cycles.
   - A later ack and pc_update cause no change until reset.
5. In EXEC, assert halt and pc_update together with PC_new=32'h80:
   - halted=1, PC unchanged, no further imem_req.
6. Set PC=32'hFFFF_FFFF via pc_update:
   - PC_incremented=0.
   - Then assert rst_n=0 mid-WAIT: imem_req, instr_valid and fetch_err clear asynchronously, and PC returns to RESET_PC.
